// File: rtl/syn_mul_div.sv
// syn_mul_div: iterative EX-stage multiply/divide unit owning the HI/LO registers.
// MULT/MULTU/DIV/DIVU take 32 RUN cycles plus one FIX cycle. MTHI/MTLO write in a single cycle.
// Ports:
//   clk, rst_n        clock; synchronous active-low reset
//   md_valid, md_op   op present in EX (0 NOP,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MTHI,6 MTLO,7 NOP)
//   ex_fwd_rf_a/b     forwarded rs/rt operands
//   md_kill           flush of the in-flight or presented op
//   md_busy           op in flight (registered)
//   md_hi, md_lo      architectural HI/LO (registered)
//   md_div_zero       one-cycle pulse after a divide-by-zero completes (registered)
module syn_mul_div (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        md_valid,
  input  logic [2:0]  md_op,
  input  logic [31:0] ex_fwd_rf_a,
  input  logic [31:0] ex_fwd_rf_b,
  input  logic        md_kill,
  output logic        md_busy,
  output logic [31:0] md_hi,
  output logic [31:0] md_lo,
  output logic        md_div_zero
);

  localparam int unsigned MD_CYC = 32;
  localparam int unsigned CNT_W  = $clog2(MD_CYC);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIX} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [63:0]       acc_q, acc_d;       // mul: {partial product, multiplier}; div: {remainder, dividend->quotient}
  logic [31:0]       opnd_q, opnd_d;     // multiplicand magnitude or divisor magnitude
  logic [31:0]       a_orig_q, a_orig_d; // raw dividend, returned in HI on divide-by-zero
  logic              is_div_q, is_div_d;
  logic              neg_res_q, neg_res_d;
  logic              neg_rem_q, neg_rem_d;
  logic              dz_q, dz_d;
  logic [31:0]       hi_d, lo_d;
  logic              busy_d, dz_pulse_d;

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (32'd0 - v) : v;
  endfunction

  // One shift-add step and one restoring-divide step, both over the shared accumulator.
  logic [32:0] mul_sum, div_shift, div_diff;
  logic [63:0] mul_next, div_next;
  always_comb begin
    mul_sum   = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? opnd_q : 32'd0)};
    mul_next  = {mul_sum, acc_q[31:1]};
    div_shift = acc_q[63:31];
    div_diff  = div_shift - {1'b0, opnd_q};
    div_next  = div_diff[32] ? {div_shift[31:0], acc_q[30:0], 1'b0}
                             : {div_diff[31:0],  acc_q[30:0], 1'b1};
  end

  // Sign-corrected results, consumed on the FIX edge.
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;
  always_comb begin
    prod_fix = neg_res_q ? (64'd0 - acc_q) : acc_q;
    quo_fix  = neg_res_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
    rem_fix  = neg_rem_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
  end

  // Operand decode for the accept edge.
  logic        op_signed, op_div, op_md;
  logic [31:0] a_mag, b_mag;
  always_comb begin
    op_signed = (md_op == OP_MULT) || (md_op == OP_DIV);
    op_div    = (md_op == OP_DIV)  || (md_op == OP_DIVU);
    op_md     = (md_op == OP_MULT) || (md_op == OP_MULTU) || op_div;
    a_mag     = op_signed ? abs32(ex_fwd_rf_a) : ex_fwd_rf_a;
    b_mag     = op_signed ? abs32(ex_fwd_rf_b) : ex_fwd_rf_b;
  end

  // Next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    a_orig_d   = a_orig_q;
    is_div_d   = is_div_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    dz_d       = dz_q;
    hi_d       = md_hi;
    lo_d       = md_lo;
    busy_d     = md_busy;
    dz_pulse_d = 1'b0;

    if (md_kill) begin
      // Flush wins over accept and over the FIX write.
      state_d = ST_IDLE;
      cnt_d   = '0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (md_valid) begin
            if (op_md) begin
              state_d   = ST_RUN;
              cnt_d     = '0;
              busy_d    = 1'b1;
              is_div_d  = op_div;
              opnd_d    = op_div ? b_mag : a_mag;
              acc_d     = {32'd0, (op_div ? a_mag : b_mag)};
              a_orig_d  = ex_fwd_rf_a;
              neg_res_d = op_signed && (ex_fwd_rf_a[31] ^ ex_fwd_rf_b[31]);
              neg_rem_d = op_signed && op_div && ex_fwd_rf_a[31];
              dz_d      = op_div && (ex_fwd_rf_b == 32'd0);
            end else if (md_op == OP_MTHI) begin
              hi_d = ex_fwd_rf_a;
            end else if (md_op == OP_MTLO) begin
              lo_d = ex_fwd_rf_a;
            end
          end
        end
        ST_RUN: begin
          acc_d = is_div_q ? div_next : mul_next;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(MD_CYC - 1)) state_d = ST_FIX;
        end
        ST_FIX: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
          if (!is_div_q) begin
            hi_d = prod_fix[63:32];
            lo_d = prod_fix[31:0];
          end else if (dz_q) begin
            hi_d       = a_orig_q;
            lo_d       = 32'hFFFF_FFFF;
            dz_pulse_d = 1'b1;
          end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      opnd_q      <= '0;
      a_orig_q    <= '0;
      is_div_q    <= 1'b0;
      neg_res_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      dz_q        <= 1'b0;
      md_hi       <= '0;
      md_lo       <= '0;
      md_busy     <= 1'b0;
      md_div_zero <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      opnd_q      <= opnd_d;
      a_orig_q    <= a_orig_d;
      is_div_q    <= is_div_d;
      neg_res_q   <= neg_res_d;
      neg_rem_q   <= neg_rem_d;
      dz_q        <= dz_d;
      md_hi       <= hi_d;
      md_lo       <= lo_d;
      md_busy     <= busy_d;
      md_div_zero <= dz_pulse_d;
    end
  end

endmodule

// File: tb/tb_syn_mul_div.sv
// tb_syn_mul_div: directed self-checking bench for syn_mul_div.
module tb_syn_mul_div;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        md_valid;
  logic [2:0]  md_op;
  logic [31:0] ex_fwd_rf_a;
  logic [31:0] ex_fwd_rf_b;
  logic        md_kill;
  logic        md_busy;
  logic [31:0] md_hi;
  logic [31:0] md_lo;
  logic        md_div_zero;

  int checks = 0;
  int errors = 0;

  syn_mul_div dut (
    .clk(clk), .rst_n(rst_n), .md_valid(md_valid), .md_op(md_op),
    .ex_fwd_rf_a(ex_fwd_rf_a), .ex_fwd_rf_b(ex_fwd_rf_b), .md_kill(md_kill),
    .md_busy(md_busy), .md_hi(md_hi), .md_lo(md_lo), .md_div_zero(md_div_zero)
  );

  always #5 clk = ~clk;

  // Present one op for exactly one edge; returns 1 time unit after that edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    md_valid = 1'b1; md_op = op; ex_fwd_rf_a = a; ex_fwd_rf_b = b;
    @(posedge clk); #1;
    md_valid = 1'b0; md_op = 3'd0;
  endtask

  // Count edges until md_busy drops (bounded); note any md_div_zero seen on the way.
  task automatic wait_done(output int n, output bit dz_seen);
    n = 0; dz_seen = 1'b0;
    do begin
      @(posedge clk); #1;
      n++;
      if (md_div_zero) dz_seen = 1'b1;
    end while (md_busy && n < 100);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; md_valid = 1'b0; md_op = 3'd0; md_kill = 1'b0;
    ex_fwd_rf_a = '0; ex_fwd_rf_b = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", md_busy); end
    checks++; if (md_hi !== 32'd0) begin errors++; $display("FAIL reset_hi got %h exp 0", md_hi); end
    checks++; if (md_lo !== 32'd0) begin errors++; $display("FAIL reset_lo got %h exp 0", md_lo); end
    checks++; if (md_div_zero !== 1'b0) begin errors++; $display("FAIL reset_dz got %0b exp 0", md_div_zero); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_multu();
    int n; bit dz;
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checks++; if (md_busy !== 1'b1) begin errors++; $display("FAIL multu_busy_e0 got %0b exp 1", md_busy); end
    checks++; if (md_lo !== 32'd0) begin errors++; $display("FAIL multu_lo_hold got %h exp 0", md_lo); end
    wait_done(n, dz);
    checks++; if (n !== 33) begin errors++; $display("FAIL multu_busy_len got %0d exp 33", n); end
    checks++; if (md_hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi got %h exp fffffffe", md_hi); end
    checks++; if (md_lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo got %h exp 00000001", md_lo); end
  endtask

  task automatic test_mult();
    int n; bit dz;
    issue(3'd1, 32'hFFFF_FFFD, 32'd7);
    wait_done(n, dz);
    checks++; if (md_hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got %h exp ffffffff", md_hi); end
    checks++; if (md_lo !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mult_lo got %h exp ffffffeb", md_lo); end
  endtask

  // Signed divide followed immediately (first legal edge) by an unsigned divide.
  task automatic test_back_to_back();
    int n; bit dz;
    issue(3'd3, 32'hFFFF_FFF9, 32'd2);
    wait_done(n, dz);
    checks++; if (md_lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo got %h exp fffffffd", md_lo); end
    checks++; if (md_hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi got %h exp ffffffff", md_hi); end
    issue(3'd4, 32'd100, 32'd7);
    checks++; if (md_busy !== 1'b1) begin errors++; $display("FAIL divu_accept got %0b exp 1", md_busy); end
    wait_done(n, dz);
    checks++; if (n !== 33) begin errors++; $display("FAIL divu_busy_len got %0d exp 33", n); end
    checks++; if (md_lo !== 32'd14) begin errors++; $display("FAIL divu_lo got %h exp 0000000e", md_lo); end
    checks++; if (md_hi !== 32'd2) begin errors++; $display("FAIL divu_hi got %h exp 00000002", md_hi); end
  endtask

  task automatic test_div_zero();
    int n; bit dz;
    issue(3'd3, 32'h0000_1234, 32'd0);
    wait_done(n, dz);
    checks++; if (md_div_zero !== 1'b1) begin errors++; $display("FAIL dz_pulse got %0b exp 1", md_div_zero); end
    checks++; if (md_lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dz_lo got %h exp ffffffff", md_lo); end
    checks++; if (md_hi !== 32'h0000_1234) begin errors++; $display("FAIL dz_hi got %h exp 00001234", md_hi); end
    @(posedge clk); #1;
    checks++; if (md_div_zero !== 1'b0) begin errors++; $display("FAIL dz_pulse_len got %0b exp 0", md_div_zero); end
  endtask

  task automatic test_overflow();
    int n; bit dz;
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(n, dz);
    @(posedge clk); #1;
    if (md_div_zero) dz = 1'b1;
    checks++; if (md_lo !== 32'h8000_0000) begin errors++; $display("FAIL ovf_lo got %h exp 80000000", md_lo); end
    checks++; if (md_hi !== 32'd0) begin errors++; $display("FAIL ovf_hi got %h exp 0", md_hi); end
    checks++; if (dz !== 1'b0) begin errors++; $display("FAIL ovf_dz got %0b exp 0", dz); end
  endtask

  // MTHI is zero-stall; an MTLO held during a multiply waits for idle.
  task automatic test_mthi_mtlo();
    int n; bit dz;
    issue(3'd5, 32'hAAAA_5555, 32'd0);
    checks++; if (md_hi !== 32'hAAAA_5555) begin errors++; $display("FAIL mthi_hi got %h exp aaaa5555", md_hi); end
    checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL mthi_busy got %0b exp 0", md_busy); end
    issue(3'd2, 32'd3, 32'd5);
    md_valid = 1'b1; md_op = 3'd6; ex_fwd_rf_a = 32'hDEAD_BEEF;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (md_lo !== 32'h8000_0000) begin errors++; $display("FAIL mtlo_busy_lo got %h exp 80000000", md_lo); end
    wait_done(n, dz);
    checks++; if (md_lo !== 32'd15) begin errors++; $display("FAIL mtlo_mul_lo got %h exp 0000000f", md_lo); end
    checks++; if (md_hi !== 32'd0) begin errors++; $display("FAIL mtlo_mul_hi got %h exp 0", md_hi); end
    @(posedge clk); #1;
    checks++; if (md_lo !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mtlo_lo got %h exp deadbeef", md_lo); end
    md_valid = 1'b0; md_op = 3'd0;
  endtask

  task automatic test_kill();
    issue(3'd2, 32'd3, 32'd5);
    repeat (10) @(posedge clk);
    #1;
    md_kill = 1'b1;
    @(posedge clk); #1;
    md_kill = 1'b0;
    checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL kill_busy got %0b exp 0", md_busy); end
    repeat (30) @(posedge clk);
    #1;
    checks++; if (md_lo !== 32'hDEAD_BEEF) begin errors++; $display("FAIL kill_lo got %h exp deadbeef", md_lo); end
    checks++; if (md_hi !== 32'd0) begin errors++; $display("FAIL kill_hi got %h exp 0", md_hi); end
    // Kill at the same edge as an MTHI blocks the write.
    @(negedge clk);
    md_valid = 1'b1; md_op = 3'd5; ex_fwd_rf_a = 32'h1357_9BDF; md_kill = 1'b1;
    @(posedge clk); #1;
    md_valid = 1'b0; md_op = 3'd0; md_kill = 1'b0;
    checks++; if (md_hi !== 32'd0) begin errors++; $display("FAIL kill_mthi_hi got %h exp 0", md_hi); end
  endtask

  task automatic test_reset_mid_run();
    issue(3'd4, 32'd1000, 32'd3);
    repeat (5) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL rstrun_busy got %0b exp 0", md_busy); end
    checks++; if (md_lo !== 32'd0) begin errors++; $display("FAIL rstrun_lo got %h exp 0", md_lo); end
    checks++; if (md_hi !== 32'd0) begin errors++; $display("FAIL rstrun_hi got %h exp 0", md_hi); end
    @(negedge clk); rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    checks++; if (md_lo !== 32'd0) begin errors++; $display("FAIL rstrun_after_lo got %h exp 0", md_lo); end
  endtask

  initial begin
    test_reset();
    test_multu();
    test_mult();
    test_back_to_back();
    test_div_zero();
    test_overflow();
    test_mthi_mtlo();
    test_kill();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/syn_mul_div.md
# syn_mul_div

Iterative multiply/divide unit in the EX stage, consuming the forwarded operands `ex_fwd_rf_a`/`ex_fwd_rf_b` produced by the EX-stage forwarding mux. It executes MULT/MULTU/DIV/DIVU over multiple cycles into the architectural HI/LO registers and performs single-cycle MTHI/MTLO writes. It raises `md_busy` so the hazard unit can stall dependent instructions, meaning any MD op or MFHI/MFLO.

## Interface
- `MD_CYC`, 32: iterations per MUL/DIV (one result bit per cycle); fixed for 32-bit operands.
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `md_valid`  in  1  an MD op is present in EX this cycle.
- `md_op`  in  3  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NOP).
- `ex_fwd_rf_a`  in  32  forwarded rs value: multiplicand, dividend, or MTHI/MTLO source.
- `ex_fwd_rf_b`  in  32  forwarded rt value: multiplier or divisor.
- `md_kill`  in  1  flush; cancels an in-flight or presented op.
- `md_busy`  out  1  registered; high while an op is in flight.
- `md_hi`  out  32  registered HI.
- `md_lo`  out  32  registered LO.
- `md_div_zero`  out  1  registered one-cycle pulse when a DIV/DIVU with a zero divisor completes.

## Operation
- Reset (`rst_n`=0 at an edge): state goes to IDLE; `md_hi`, `md_lo`, `md_busy`, `md_div_zero` all become 0; iteration counter becomes 0. Reset overrides everything, including mid-operation.
- States:
  - IDLE → RUN on accept of ops 1–4.
  - RUN → FIX after `MD_CYC` iterations.
  - FIX → IDLE after writing HI/LO.
- Accept: state IDLE, `md_valid`=1, `md_kill`=0.
  - Ops 1–4: latch operand magnitudes (absolute value for signed ops, raw for unsigned), the result sign flags and the divisor-zero flag; then enter RUN with counter=0.
  - MTHI/MTLO: write `ex_fwd_rf_a` to HI/LO at that edge; stay IDLE; `md_busy` is not raised.
- `md_valid` while busy is ignored: no latch, no state change. The hazard unit must hold the op until `md_busy`=0.
- RUN, multiply: radix-2 shift-add over a 64-bit accumulator, one multiplier bit per cycle.
- RUN, divide: restoring division, one quotient bit per cycle, with a 33-bit partial-remainder subtract.
- FIX, sign correction:
  - Product: 64-bit two's-complement negate if the operand signs differ (signed op only).
  - Quotient: negated if the signs differ.
  - Remainder: takes the sign of the dividend.
- FIX, write: HI={product[63:32] | remainder}, LO={product[31:0] | quotient}.
- Divide by zero (either signedness): LO=32'hFFFF_FFFF, HI=original `ex_fwd_rf_a`; `md_div_zero` pulses for the cycle after the FIX edge.
- Signed overflow 0x8000_0000 / 0xFFFF_FFFF: LO=0x8000_0000, HI=0. This falls out of the magnitude arithmetic; no special case is needed.
- `md_kill`=1 at an edge, any non-reset state: go to IDLE, counter=0, HI/LO unchanged. No accept occurs at that edge, even with `md_valid`=1. No `md_div_zero` pulse.

## Timing
- Edge E0 accepts MUL/DIV. `md_busy`=1 from after E0 through the cycle before E33, i.e. 33 cycles.
- RUN edges: E1..E32. The FIX edge E33 writes HI/LO and clears `md_busy`.
- Earliest next accept is E34. Earliest MFHI/MFLO read of the new value is the cycle after E33.
- MTHI/MTLO: HI/LO visible the cycle after the accept edge; zero stall.
- `md_hi`/`md_lo` hold their previous values throughout RUN/FIX until E33.
- `md_busy`, `md_hi`, `md_lo` and `md_div_zero` are all flop outputs; there is no combinational input-to-output path.
- Simultaneous `md_kill` and FIX edge: kill wins; HI/LO are not written.

## Test plan
- Reset, then MULTU a=0xFFFF_FFFF, b=0xFFFF_FFFF → `md_busy` high exactly 33 cycles; HI=0xFFFF_FFFE, LO=0x0000_0001 after E33.
- MULT a=0xFFFF_FFFD (−3), b=7 → HI=0xFFFF_FFFF, LO=0xFFFF_FFEB.
- DIV a=0xFFFF_FFF9 (−7), b=2 → LO=0xFFFF_FFFD, HI=0xFFFF_FFFF. DIVU a=100, b=7 → LO=14, HI=2.
- DIV a=0x1234, b=0 → LO=0xFFFF_FFFF, HI=0x1234, `md_div_zero`=1 for exactly one cycle.
- DIV a=0x8000_0000, b=0xFFFF_FFFF → LO=0x8000_0000, HI=0, no `md_div_zero` pulse.
- MTHI 0xAAAA_5555 → HI updates next cycle with no busy. Then MULTU 3×5 with `md_valid`+MTLO held during busy → MTLO ignored until idle.
- `md_kill` at counter=10 → IDLE next cycle, HI/LO keep prior values.
- `rst_n`=0 mid-RUN → all outputs 0 next cycle.
